// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_pkg
//  Description : Shared types and constants for the seven-segment display
//                driver: digit code type, special codes, slot index type and
//                a one-hot helper for the digit enables.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

    // 5-bit digit code as packed into the game display word
    typedef logic [4:0] seg_code_t;

    // Digit-slot index, 0 = leftmost digit
    typedef logic [1:0] seg_idx_t;

    localparam seg_code_t   SEG_CODE_DASH  = 5'h10;
    localparam seg_code_t   SEG_CODE_BLANK = 5'h1F;
    localparam logic [6:0]  SEG_OFF        = 7'h7F;

    // One-hot digit enable for a slot index
    function automatic logic [3:0] seg_onehot(input seg_idx_t idx);
        return 4'b0001 << idx;
    endfunction

endpackage : seg_pkg
`default_nettype wire

// File: rtl/seg_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg_decode
//  Description : Combinational decoder from a 5-bit digit code to an
//                active-low seven-segment pattern (bit0 = a ... bit6 = g).
//                Codes 0x00-0x0F show hex digits, 0x10 shows a dash, every
//                other code shows blank.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_decode
    import seg_pkg::*;
(
    input  seg_code_t   code,
    output logic [6:0]  segs
);

    // Code-to-pattern lookup; anything not listed is blank
    always_comb begin
        segs = SEG_OFF;
        case (code)
            5'h00:         segs = 7'h40;
            5'h01:         segs = 7'h79;
            5'h02:         segs = 7'h24;
            5'h03:         segs = 7'h30;
            5'h04:         segs = 7'h19;
            5'h05:         segs = 7'h12;
            5'h06:         segs = 7'h02;
            5'h07:         segs = 7'h78;
            5'h08:         segs = 7'h00;
            5'h09:         segs = 7'h10;
            5'h0A:         segs = 7'h08;
            5'h0B:         segs = 7'h03;
            5'h0C:         segs = 7'h46;
            5'h0D:         segs = 7'h21;
            5'h0E:         segs = 7'h06;
            5'h0F:         segs = 7'h0E;
            SEG_CODE_DASH: segs = 7'h3F;
            default:       segs = SEG_OFF;
        endcase
    end

endmodule : seg_decode
`default_nettype wire

// File: rtl/seg_display_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg_display_driver
//  Description : Time-multiplexed driver for a common-segment 4-digit
//                seven-segment display. The packed 20-bit word is captured
//                into a shadow register once per frame (tear-free), and each
//                digit slot starts with a blanking gap to suppress ghosting.
//                All outputs are registered.
//  Build macro : SEG_DISPLAY_BLINK_EN - enables whole-display blinking
//                driven by victoryflag, sampled once per frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_display_driver
    import seg_pkg::*;
#(
    parameter int DIGIT_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [19:0] bits,
    input  logic        victoryflag,
    output logic [6:0]  segs,
    output logic [3:0]  digit_en,
    output logic        frame_start
);

    localparam int c_cnt_w = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;

    logic [c_cnt_w-1:0] r_cnt;
    seg_idx_t           r_idx;
    logic [19:0]        r_shadow;

    logic               w_load;
    logic               w_slot_end;
    logic               w_blank_phase;
    logic               w_visible;
    logic [19:0]        w_shadow_now;
    seg_code_t          w_code;
    logic [6:0]         w_seg_pat;

    // Frame boundary: first cycle of slot 0
    assign w_load        = (r_cnt == '0) && (r_idx == 2'd0);
    assign w_slot_end    = (r_cnt == c_cnt_w'(DIGIT_CYCLES - 1));
    assign w_blank_phase = (r_cnt < c_cnt_w'(BLANK_CYCLES));

    // Use the word being captured this edge so a zero-length blank gap
    // still shows the freshly loaded frame on slot 0
    assign w_shadow_now = w_load ? bits : r_shadow;

    // Select the code of the active slot; digit 0 sits in the top field
    always_comb begin
        w_code = SEG_CODE_BLANK;
        case (r_idx)
            2'd0:    w_code = w_shadow_now[19:15];
            2'd1:    w_code = w_shadow_now[14:10];
            2'd2:    w_code = w_shadow_now[9:5];
            default: w_code = w_shadow_now[4:0];
        endcase
    end

    seg_decode u_decode (
        .code (w_code),
        .segs (w_seg_pat)
    );

`ifdef SEG_DISPLAY_BLINK_EN
    localparam int c_bcnt_w = $clog2(BLINK_FRAMES + 1);

    logic [c_bcnt_w-1:0] r_bcnt;
    logic                r_dark;
    logic [c_bcnt_w-1:0] w_bcnt_next;
    logic                w_dark_next;

    // Blink state advances only on frame loads; r_bcnt counts frames already
    // shown in the current half-period, so a fresh flag starts visible
    always_comb begin
        w_bcnt_next = r_bcnt;
        w_dark_next = r_dark;
        if (w_load) begin
            if (!victoryflag) begin
                w_bcnt_next = '0;
                w_dark_next = 1'b0;
            end else if (r_bcnt == c_bcnt_w'(BLINK_FRAMES)) begin
                w_bcnt_next = c_bcnt_w'(1);
                w_dark_next = ~r_dark;
            end else begin
                w_bcnt_next = r_bcnt + 1'b1;
            end
        end
    end

    // Blink state registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_bcnt <= '0;
            r_dark <= 1'b0;
        end else begin
            r_bcnt <= w_bcnt_next;
            r_dark <= w_dark_next;
        end
    end

    assign w_visible = ~w_dark_next;
`else
    localparam int c_unused_blink_frames = BLINK_FRAMES;
    logic          w_unused_victoryflag;

    assign w_unused_victoryflag = victoryflag;
    assign w_visible            = 1'b1;
`endif

    // Slot/frame counters, shadow capture and registered pin drive
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt       <= '0;
            r_idx       <= 2'd0;
            r_shadow    <= 20'hFFFFF;
            segs        <= SEG_OFF;
            digit_en    <= 4'h0;
            frame_start <= 1'b0;
        end else begin
            if (w_slot_end) begin
                r_cnt <= '0;
                r_idx <= r_idx + 2'd1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_load) begin
                r_shadow <= bits;
            end
            frame_start <= w_load;

            if (w_blank_phase || !w_visible) begin
                digit_en <= 4'h0;
                segs     <= SEG_OFF;
            end else begin
                digit_en <= seg_onehot(r_idx);
                segs     <= w_seg_pat;
            end
        end
    end

endmodule : seg_display_driver
`default_nettype wire
